// File: rtl/adder_la_host.sv
// adder_la_host: LFSR-driven test host for an instrumented 32-bit adder.
// Generates operand pairs, strobes the adder, checks sums and keeps saturating
// pass/error/timeout counters per run.
// Optional feature macro: HOST_FIRST_FAIL_CAPTURE_EN adds fail_a/fail_b/fail_s/
// fail_valid capture of the first miscompare in a run.
module adder_la_host #(
  parameter logic [31:0] SEED    = 32'hACE1_2468,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [15:0] num_tests,
  output logic        adder_rst,
  output logic        adder_run,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  input  logic [31:0] s_in,
  input  logic        done_in,
  output logic        busy,
  output logic        run_done,
  output logic [15:0] pass_count,
  output logic [15:0] err_count,
  output logic [15:0] timeout_count
`ifdef HOST_FIRST_FAIL_CAPTURE_EN
  ,
  output logic [31:0] fail_a,
  output logic [31:0] fail_b,
  output logic [31:0] fail_s,
  output logic        fail_valid
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [DW-1:0] TAPS     = 32'h8020_0003;
  localparam logic [DW-1:0] TMO_LAST = DW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, CHECK, FINISH} state_t;

  state_t          state;
  logic [DW-1:0]   lfsr;
  logic [DW-1:0]   lfsr_b;
  logic [DW-1:0]   lfsr_n2;
  logic [DW-1:0]   sum_exp;
  logic [DW-1:0]   timer;
  logic [CW-1:0]   tests_left;
  logic            timed_out;

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] v);
    return {1'b0, v[DW-1:1]} ^ (v[0] ? TAPS : '0);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // Next two LFSR values (operand B and the post-load state) and expected sum
  assign lfsr_b  = lfsr_step(lfsr);
  assign lfsr_n2 = lfsr_step(lfsr_b);
  assign sum_exp = a_out + b_out;

  // Host FSM; operands are loaded (and the LFSR stepped twice) as the FSM enters LOAD
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      lfsr          <= SEED;
      adder_rst     <= 1'b1;
      adder_run     <= 1'b0;
      a_out         <= '0;
      b_out         <= '0;
      busy          <= 1'b0;
      run_done      <= 1'b0;
      pass_count    <= '0;
      err_count     <= '0;
      timeout_count <= '0;
      tests_left    <= '0;
      timer         <= '0;
      timed_out     <= 1'b0;
`ifdef HOST_FIRST_FAIL_CAPTURE_EN
      fail_a        <= '0;
      fail_b        <= '0;
      fail_s        <= '0;
      fail_valid    <= 1'b0;
`endif
    end else begin
      run_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            pass_count    <= '0;
            err_count     <= '0;
            timeout_count <= '0;
`ifdef HOST_FIRST_FAIL_CAPTURE_EN
            fail_valid    <= 1'b0;
`endif
            if (num_tests != '0) begin
              tests_left <= num_tests;
              busy       <= 1'b1;
              a_out      <= lfsr;
              b_out      <= lfsr_b;
              lfsr       <= lfsr_n2;
              adder_rst  <= 1'b1;
              state      <= LOAD;
            end else begin
              run_done <= 1'b1;
            end
          end
        end
        LOAD: begin
          adder_rst <= 1'b0;
          adder_run <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          timer     <= '0;
          timed_out <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          // done_in wins over a timeout expiring in the same cycle
          if (done_in) begin
            adder_run <= 1'b0;
            state     <= CHECK;
          end else if (timer == TMO_LAST) begin
            err_count     <= sat_inc(err_count);
            timeout_count <= sat_inc(timeout_count);
            timed_out     <= 1'b1;
            adder_run     <= 1'b0;
            state         <= CHECK;
          end else begin
            timer <= timer + DW'(1);
          end
        end
        CHECK: begin
          if (!timed_out) begin
            if (s_in == sum_exp) begin
              pass_count <= sat_inc(pass_count);
            end else begin
              err_count <= sat_inc(err_count);
`ifdef HOST_FIRST_FAIL_CAPTURE_EN
              if (!fail_valid) begin
                fail_a     <= a_out;
                fail_b     <= b_out;
                fail_s     <= s_in;
                fail_valid <= 1'b1;
              end
`endif
            end
          end
          if (tests_left == CW'(1)) begin
            run_done <= 1'b1;
            state    <= FINISH;
          end else begin
            tests_left <= tests_left - CW'(1);
            a_out      <= lfsr;
            b_out      <= lfsr_b;
            lfsr       <= lfsr_n2;
            adder_rst  <= 1'b1;
            state      <= LOAD;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_la_host.sv
// tb_adder_la_host: scoreboard bench for adder_la_host with a behavioural adder.
module tb_adder_la_host;

  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  localparam int unsigned TMO  = 16;

  logic        wb_clk_i  = 1'b0;
  logic        wb_rst_i  = 1'b1;
  logic        start     = 1'b0;
  logic [15:0] num_tests = '0;
  logic [31:0] s_in      = '0;
  logic        done_in   = 1'b0;
  logic        adder_rst, adder_run, busy, run_done;
  logic [31:0] a_out, b_out;
  logic [15:0] pass_count, err_count, timeout_count;
`ifdef HOST_FIRST_FAIL_CAPTURE_EN
  logic [31:0] fail_a, fail_b, fail_s;
  logic        fail_valid;
`endif

  adder_la_host #(.SEED(SEED), .TIMEOUT(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .num_tests(num_tests),
    .adder_rst(adder_rst), .adder_run(adder_run), .a_out(a_out), .b_out(b_out),
    .s_in(s_in), .done_in(done_in), .busy(busy), .run_done(run_done),
    .pass_count(pass_count), .err_count(err_count), .timeout_count(timeout_count)
`ifdef HOST_FIRST_FAIL_CAPTURE_EN
    , .fail_a(fail_a), .fail_b(fail_b), .fail_s(fail_s), .fail_valid(fail_valid)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int passed = 0;

  // Adder model controls: 0 correct, 1 corrupt test corrupt_idx, 2 never done, 3 constant sum
  int          mode = 0;
  int          corrupt_idx = 0;
  logic [31:0] const_sum = '0;
  int          mcyc = 0;
  int          run_idx = 0;

  // Behavioural adder: answers 3 cycles after adder_run rises, holds done while run is high
  always @(negedge wb_clk_i) begin
    if (wb_rst_i || adder_rst || !adder_run) begin
      mcyc = 0;
      done_in = 1'b0;
    end else begin
      mcyc = mcyc + 1;
      if (mcyc == 3 && mode != 2) begin
        s_in = (mode == 3) ? const_sum : a_out + b_out;
        if (mode == 1 && run_idx == corrupt_idx) s_in = s_in ^ 32'd1;
        done_in = 1'b1;
      end
    end
  end

  // Independent LFSR model built from the polynomial exponents 32, 22, 2, 1
  logic [31:0] mdl_lfsr;
  function automatic logic [31:0] mstep(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) begin
      r[31] = ~r[31]; r[21] = ~r[21]; r[1] = ~r[1]; r[0] = ~r[0];
    end
    return r;
  endfunction

  logic [31:0] exp_a_q[$], exp_b_q[$], obs_a[$], obs_b[$];
  logic [31:0] ea, eb, oa, ob;
  int done_pulses, run_cycles, busy_gap;
  bit run_hung;

  task automatic push_expected(input int n);
    for (int i = 0; i < n; i++) begin
      exp_a_q.push_back(mdl_lfsr); mdl_lfsr = mstep(mdl_lfsr);
      exp_b_q.push_back(mdl_lfsr); mdl_lfsr = mstep(mdl_lfsr);
    end
  endtask

  // Start a run and record operands, run_done pulses and timing (no checking here)
  task automatic do_run(input logic [15:0] n, input int poke);
    int cyc; int tail; logic prev_run;
    run_idx = 0; done_pulses = 0; run_cycles = 0; busy_gap = 0; run_hung = 0;
    obs_a.delete(); obs_b.delete();
    @(negedge wb_clk_i); start = 1'b1; num_tests = n;
    @(negedge wb_clk_i); start = 1'b0;
    cyc = 1; tail = -1; prev_run = 1'b0;
    forever begin
      if (adder_run && !prev_run) begin
        run_idx++; obs_a.push_back(a_out); obs_b.push_back(b_out);
      end
      prev_run = adder_run;
      if (n != 0 && tail < 0 && !busy) busy_gap++;
      if (run_done) begin
        done_pulses++;
        if (tail < 0) begin run_cycles = cyc; tail = 3; end
      end
      if (tail == 0) break;
      if (tail > 0) tail--;
      if (cyc > 2000) begin run_hung = 1; break; end
      @(negedge wb_clk_i);
      cyc++;
      start = (poke > 0) && (cyc == poke || cyc == poke + 2);
      num_tests = (cyc == poke + 2) ? 16'd9 : 16'd0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    checks++; if (adder_rst !== 1'b1) $display("FAIL rst_adder_rst got %b want 1", adder_rst); else passed++;
    checks++; if (adder_run !== 1'b0) $display("FAIL rst_adder_run got %b want 0", adder_run); else passed++;
    checks++; if (run_done !== 1'b0) $display("FAIL rst_run_done got %b want 0", run_done); else passed++;
    checks++; if ({a_out, b_out} !== 64'd0) $display("FAIL rst_ops got %h/%h want 0/0", a_out, b_out); else passed++;
    checks++; if ({pass_count, err_count, timeout_count} !== 48'd0)
      $display("FAIL rst_counts got %0d/%0d/%0d want 0/0/0", pass_count, err_count, timeout_count); else passed++;
    wb_rst_i = 1'b0;
    mdl_lfsr = SEED;
  endtask

  // Seed 0xFFFFFFFF gives A=FFFFFFFF, B=FFDFFFFC; the true sum wraps to FFDFFFFB
  task automatic test_wrap;
    mode = 3; const_sum = 32'hFFDF_FFFB;
    push_expected(1);
    do_run(16'd1, 0);
    checks++; if (run_hung) $display("FAIL wrap_hang got hung want done"); else passed++;
    checks++; if (obs_a.size() > 0 && obs_a[0] !== 32'hFFFF_FFFF) $display("FAIL wrap_a got %h want ffffffff", obs_a[0]); else passed++;
    checks++; if (obs_b.size() > 0 && obs_b[0] !== 32'hFFDF_FFFC) $display("FAIL wrap_b got %h want ffdffffc", obs_b[0]); else passed++;
    checks++; if (obs_a.size() != 1) $display("FAIL wrap_nops got %0d want 1", obs_a.size()); else passed++;
    while (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      oa = (obs_a.size() > 0) ? obs_a.pop_front() : 'x; ob = (obs_b.size() > 0) ? obs_b.pop_front() : 'x;
      checks++; if (oa !== ea || ob !== eb) $display("FAIL wrap_ops got %h/%h want %h/%h", oa, ob, ea, eb); else passed++;
    end
    checks++; if (pass_count !== 16'd1 || err_count !== 16'd0)
      $display("FAIL wrap_counts got %0d/%0d want 1/0", pass_count, err_count); else passed++;
`ifdef HOST_FIRST_FAIL_CAPTURE_EN
    checks++; if (fail_valid !== 1'b0) $display("FAIL wrap_fail_valid got %b want 0", fail_valid); else passed++;
`endif
  endtask

  task automatic test_pass;
    mode = 0;
    push_expected(4);
    do_run(16'd4, 0);
    checks++; if (run_hung) $display("FAIL pass_hang got hung want done"); else passed++;
    checks++; if (obs_a.size() != 4) $display("FAIL pass_nops got %0d want 4", obs_a.size()); else passed++;
    while (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      oa = (obs_a.size() > 0) ? obs_a.pop_front() : 'x; ob = (obs_b.size() > 0) ? obs_b.pop_front() : 'x;
      checks++; if (oa !== ea || ob !== eb) $display("FAIL pass_ops got %h/%h want %h/%h", oa, ob, ea, eb); else passed++;
    end
    checks++; if (pass_count !== 16'd4) $display("FAIL pass_pass got %0d want 4", pass_count); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL pass_err got %0d want 0", err_count); else passed++;
    checks++; if (done_pulses != 1) $display("FAIL pass_done_pulses got %0d want 1", done_pulses); else passed++;
    checks++; if (busy_gap != 0) $display("FAIL pass_busy_gap got %0d want 0", busy_gap); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL pass_busy_after got %b want 0", busy); else passed++;
  endtask

  task automatic test_corrupt;
    logic [31:0] a2, b2;
    mode = 1; corrupt_idx = 2;
    push_expected(3);
    a2 = exp_a_q[1]; b2 = exp_b_q[1];
    do_run(16'd3, 0);
    checks++; if (run_hung) $display("FAIL corrupt_hang got hung want done"); else passed++;
    checks++; if (obs_a.size() != 3) $display("FAIL corrupt_nops got %0d want 3", obs_a.size()); else passed++;
    while (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      oa = (obs_a.size() > 0) ? obs_a.pop_front() : 'x; ob = (obs_b.size() > 0) ? obs_b.pop_front() : 'x;
      checks++; if (oa !== ea || ob !== eb) $display("FAIL corrupt_ops got %h/%h want %h/%h", oa, ob, ea, eb); else passed++;
    end
    checks++; if (pass_count !== 16'd2 || err_count !== 16'd1 || timeout_count !== 16'd0)
      $display("FAIL corrupt_counts got %0d/%0d/%0d want 2/1/0", pass_count, err_count, timeout_count); else passed++;
`ifdef HOST_FIRST_FAIL_CAPTURE_EN
    checks++; if (fail_valid !== 1'b1) $display("FAIL corrupt_fail_valid got %b want 1", fail_valid); else passed++;
    checks++; if (fail_a !== a2 || fail_b !== b2) $display("FAIL corrupt_fail_ops got %h/%h want %h/%h", fail_a, fail_b, a2, b2); else passed++;
    checks++; if (fail_s !== ((a2 + b2) ^ 32'd1)) $display("FAIL corrupt_fail_s got %h want %h", fail_s, (a2 + b2) ^ 32'd1); else passed++;
`endif
  endtask

  task automatic test_timeout;
    mode = 2;
    push_expected(2);
    do_run(16'd2, 0);
    checks++; if (run_hung) $display("FAIL tmo_hang got hung want done"); else passed++;
    checks++; if (obs_a.size() != 2) $display("FAIL tmo_nops got %0d want 2", obs_a.size()); else passed++;
    while (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      oa = (obs_a.size() > 0) ? obs_a.pop_front() : 'x; ob = (obs_b.size() > 0) ? obs_b.pop_front() : 'x;
      checks++; if (oa !== ea || ob !== eb) $display("FAIL tmo_ops got %h/%h want %h/%h", oa, ob, ea, eb); else passed++;
    end
    checks++; if (pass_count !== 16'd0 || err_count !== 16'd2 || timeout_count !== 16'd2)
      $display("FAIL tmo_counts got %0d/%0d/%0d want 0/2/2", pass_count, err_count, timeout_count); else passed++;
    // Per test: LOAD + RUN + TMO wait cycles + CHECK, then FINISH
    checks++; if (run_cycles != 2 * (TMO + 3) + 1) $display("FAIL tmo_cycles got %0d want %0d", run_cycles, 2 * (TMO + 3) + 1); else passed++;
  endtask

  task automatic test_busy_start;
    mode = 0;
    push_expected(3);
    do_run(16'd3, 4);
    checks++; if (run_hung) $display("FAIL busy_start_hang got hung want done"); else passed++;
    checks++; if (obs_a.size() != 3) $display("FAIL busy_start_nops got %0d want 3", obs_a.size()); else passed++;
    while (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      oa = (obs_a.size() > 0) ? obs_a.pop_front() : 'x; ob = (obs_b.size() > 0) ? obs_b.pop_front() : 'x;
      checks++; if (oa !== ea || ob !== eb) $display("FAIL busy_start_ops got %h/%h want %h/%h", oa, ob, ea, eb); else passed++;
    end
    checks++; if (pass_count !== 16'd3 || err_count !== 16'd0)
      $display("FAIL busy_start_counts got %0d/%0d want 3/0", pass_count, err_count); else passed++;
    checks++; if (done_pulses != 1) $display("FAIL busy_start_done_pulses got %0d want 1", done_pulses); else passed++;
  endtask

  task automatic test_zero;
    mode = 0;
    do_run(16'd0, 0);
    checks++; if (run_hung) $display("FAIL zero_hang got hung want done"); else passed++;
    checks++; if (done_pulses != 1 || run_cycles != 1)
      $display("FAIL zero_done got pulses=%0d at=%0d want 1 at 1", done_pulses, run_cycles); else passed++;
    checks++; if ({pass_count, err_count, timeout_count} !== 48'd0)
      $display("FAIL zero_counts got %0d/%0d/%0d want 0/0/0", pass_count, err_count, timeout_count); else passed++;
    checks++; if (obs_a.size() != 0 || busy !== 1'b0) $display("FAIL zero_idle got ops=%0d busy=%b want 0/0", obs_a.size(), busy); else passed++;
  endtask

  task automatic test_reset_mid;
    int cyc; int pulses;
    mode = 2; run_idx = 0;
    @(negedge wb_clk_i); start = 1'b1; num_tests = 16'd2;
    @(negedge wb_clk_i); start = 1'b0;
    cyc = 0;
    while (!(err_count === 16'd1 && adder_run === 1'b1) && cyc < 200) begin
      @(negedge wb_clk_i); cyc++;
    end
    checks++; if (cyc >= 200) $display("FAIL mid_reach_wait got timeout want second test running"); else passed++;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else passed++;
    checks++; if (adder_rst !== 1'b1 || adder_run !== 1'b0)
      $display("FAIL mid_adder_ctl got rst=%b run=%b want 1/0", adder_rst, adder_run); else passed++;
    checks++; if ({pass_count, err_count, timeout_count} !== 48'd0)
      $display("FAIL mid_counts got %0d/%0d/%0d want 0/0/0", pass_count, err_count, timeout_count); else passed++;
    pulses = (run_done === 1'b1) ? 1 : 0;
    repeat (25) begin
      @(negedge wb_clk_i);
      if (run_done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL mid_no_done got %0d want 0", pulses); else passed++;
    mdl_lfsr = SEED; mode = 0;
    push_expected(2);
    do_run(16'd2, 0);
    checks++; if (run_hung) $display("FAIL mid_rerun_hang got hung want done"); else passed++;
    checks++; if (obs_a.size() != 2) $display("FAIL mid_rerun_nops got %0d want 2", obs_a.size()); else passed++;
    while (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      oa = (obs_a.size() > 0) ? obs_a.pop_front() : 'x; ob = (obs_b.size() > 0) ? obs_b.pop_front() : 'x;
      checks++; if (oa !== ea || ob !== eb) $display("FAIL mid_rerun_ops got %h/%h want %h/%h", oa, ob, ea, eb); else passed++;
    end
    checks++; if (pass_count !== 16'd2 || err_count !== 16'd0)
      $display("FAIL mid_rerun_counts got %0d/%0d want 2/0", pass_count, err_count); else passed++;
  endtask

  initial begin
    test_reset;
    test_wrap;
    test_pass;
    test_corrupt;
    test_timeout;
    test_busy_start;
    test_zero;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1);
  end

endmodule
